// File: rtl/cnu_pkg.sv
// Shared definitions for the serial check-node unit: default widths, FSM states, saturation helper.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package cnu_pkg;

    localparam int CNU_DC_MAX = 8;   // maximum check-node degree (message buffer depth)
    localparam int CNU_MW     = 6;   // message magnitude width, phi LUT input code
    localparam int CNU_LW     = 4;   // phi LUT output code width

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2
    } cnu_state_e;

    // a - b clipped to [0, max_v]; the extrinsic phi sum can exceed the LUT input range
    function automatic int unsigned sat_sub(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned max_v);
        int unsigned r;
        r = (a > b) ? (a - b) : 0;
        return (r > max_v) ? max_v : r;
    endfunction

endpackage

// File: rtl/cnu_phi_scheduler_if.sv
// Handshake bundle between the CNU, the VN message memory (input side) and the CN->VN path.
// Latency: n/a (wires only).  Backpressure: in_valid/in_ready and out_valid/out_ready pairs.
// Optional: chk_ok exists only when CNU_PARITY_OUT_EN is defined.
// Ports: start/cfg_dc control, in_* message input, out_* extrinsic output, busy status.
interface cnu_phi_scheduler_if
    import cnu_pkg::*;
#(
    parameter int MW = CNU_MW
);
    logic          start;
    logic [3:0]    cfg_dc;
    logic          in_valid;
    logic          in_ready;
    logic          in_sign;
    logic [MW-1:0] in_mag;
    logic          out_valid;
    logic          out_ready;
    logic          out_sign;
    logic [MW-1:0] out_mag;
    logic          out_last;
    logic          busy;
`ifdef CNU_PARITY_OUT_EN
    logic          chk_ok;
`endif

    // master: the environment driving the CNU
    modport master (
        output start, cfg_dc, in_valid, in_sign, in_mag, out_ready,
        input  in_ready, out_valid, out_sign, out_mag, out_last, busy
`ifdef CNU_PARITY_OUT_EN
        , input chk_ok
`endif
    );

    // slave: the CNU itself
    modport slave (
        input  start, cfg_dc, in_valid, in_sign, in_mag, out_ready,
        output in_ready, out_valid, out_sign, out_mag, out_last, busy
`ifdef CNU_PARITY_OUT_EN
        , output chk_ok
`endif
    );

endinterface

// File: rtl/cnu_phi_scheduler_lut.sv
// phi(x) = log((1+e^-x)/(1-e^-x)) lookup; x code LSB 0.25, y code LSB 0.25, rounded, y clipped at 15.
// Latency: combinational.  Backpressure: none.
// Ports: x_i 6b magnitude code in, y_o 4b phi code out.
module cnu_phi_lut (
    input  logic [5:0] x_i,
    output logic [3:0] y_o
);
    always_comb begin
        y_o = 4'd0;                    // x >= 3.0: phi < 0.125, rounds to 0
        case (x_i)
            6'd0:  y_o = 4'd15;        // phi(0) is infinite, clipped
            6'd1:  y_o = 4'd8;
            6'd2:  y_o = 4'd6;
            6'd3:  y_o = 4'd4;
            6'd4:  y_o = 4'd3;
            6'd5:  y_o = 4'd2;
            6'd6:  y_o = 4'd2;
            6'd7:  y_o = 4'd1;
            6'd8:  y_o = 4'd1;
            6'd9:  y_o = 4'd1;
            6'd10: y_o = 4'd1;
            6'd11: y_o = 4'd1;
            default: y_o = 4'd0;
        endcase
    end
endmodule

// File: rtl/cnu_phi_scheduler.sv
// Serial sum-product check-node controller sharing one phi LUT between a load pass and an emit pass.
// Latency: dc accept cycles, then first out_valid one cycle after EMIT entry; 1 output/cycle after.
// Backpressure: in_ready only in LOAD; output register holds while out_valid & !out_ready.
// Ports: clk, rst (sync, active-high), bus (cnu_phi_scheduler_if.slave).
// Optional: CNU_PARITY_OUT_EN adds bus.chk_ok (= ~parity, qualified by out_last & out_valid).
module cnu_phi_scheduler
    import cnu_pkg::*;
#(
    parameter int DC_MAX = CNU_DC_MAX,
    parameter int MW     = CNU_MW,
    parameter int LW     = CNU_LW
)(
    input logic                clk,
    input logic                rst,
    cnu_phi_scheduler_if.slave bus
);
    localparam int AW = $clog2(DC_MAX * (2**LW - 1) + 1);
    localparam int IW = $clog2(DC_MAX);

    cnu_state_e    state_q;
    logic [3:0]    dc_q;
    logic [3:0]    dc_d;
    logic [IW-1:0] idx_q;
    logic [AW-1:0] acc_q;
    logic          parity_q;
    logic          sent_all_q;    // all dc outputs loaded, waiting for the final handshake
    logic          sign_buf_q [DC_MAX];
    logic [LW-1:0] phi_buf_q  [DC_MAX];
    logic          out_valid_q;
    logic          out_sign_q;
    logic          out_last_q;
    logic [MW-1:0] out_mag_q;
`ifdef CNU_PARITY_OUT_EN
    logic          chk_ok_q;
`endif

    logic [MW-1:0] lut_x;
    logic [LW-1:0] lut_y;
    logic          idx_last;
    logic          in_fire;
    logic          out_fire;
    logic          out_load;

    assign idx_last = (4'(idx_q) == dc_q - 4'd1);
    assign in_fire  = (state_q == LOAD) && bus.in_valid;
    assign out_fire = out_valid_q && bus.out_ready;
    assign out_load = (state_q == EMIT) && !sent_all_q && (!out_valid_q || bus.out_ready);

    always_comb begin
        dc_d = bus.cfg_dc;
        if (bus.cfg_dc < 4'd2)
            dc_d = 4'd2;
        else if (bus.cfg_dc > 4'(DC_MAX))
            dc_d = 4'(DC_MAX);
    end

    // LOAD converts incoming magnitudes; otherwise the LUT evaluates the extrinsic sum
    assign lut_x = (state_q == LOAD) ? bus.in_mag
                 : MW'(sat_sub(32'(acc_q), 32'(phi_buf_q[idx_q]), (2**MW) - 1));

    cnu_phi_lut u_lut (
        .x_i (lut_x),
        .y_o (lut_y)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dc_q        <= 4'd2;
            idx_q       <= '0;
            acc_q       <= '0;
            parity_q    <= 1'b0;
            sent_all_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_last_q  <= 1'b0;
            out_mag_q   <= '0;
`ifdef CNU_PARITY_OUT_EN
            chk_ok_q    <= 1'b0;
`endif
            for (int i = 0; i < DC_MAX; i++) begin
                sign_buf_q[i] <= 1'b0;
                phi_buf_q[i]  <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_q    <= LOAD;
                        dc_q       <= dc_d;
                        idx_q      <= '0;
                        acc_q      <= '0;
                        parity_q   <= 1'b0;
                        sent_all_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (in_fire) begin
                        sign_buf_q[idx_q] <= bus.in_sign;
                        phi_buf_q[idx_q]  <= lut_y;
                        acc_q             <= acc_q + AW'(lut_y);
                        parity_q          <= parity_q ^ bus.in_sign;
                        if (idx_last) begin
                            idx_q   <= '0;
                            state_q <= EMIT;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_load) begin
                        out_valid_q <= 1'b1;
                        out_mag_q   <= MW'(lut_y);
                        out_sign_q  <= parity_q ^ sign_buf_q[idx_q];
                        out_last_q  <= idx_last;
`ifdef CNU_PARITY_OUT_EN
                        chk_ok_q    <= idx_last & ~parity_q;
`endif
                        idx_q       <= idx_q + IW'(1);
                        if (idx_last)
                            sent_all_q <= 1'b1;
                    end else if (out_fire) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
`ifdef CNU_PARITY_OUT_EN
                        chk_ok_q    <= 1'b0;
`endif
                        if (out_last_q)
                            state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == LOAD);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sign  = out_sign_q;
    assign bus.out_mag   = out_mag_q;
    assign bus.out_last  = out_last_q;
`ifdef CNU_PARITY_OUT_EN
    assign bus.chk_ok    = chk_ok_q;
`endif

endmodule

// File: tb/tb_cnu_phi_scheduler.sv
// Bench for cnu_phi_scheduler: directed check-node vectors, expected outputs queued at issue time.
// Latency: n/a.  Backpressure: out_ready stalled mid-EMIT in one vector.
// Optional: CNU_PARITY_OUT_EN enables chk_ok comparisons and the parity-status vectors.
module tb_cnu_phi_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cnu_phi_scheduler_if #(.MW(6)) bus ();

    cnu_phi_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       sign;
        logic [5:0] mag;
        logic       last;
        logic       chk;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // current vector: input mags/signs, hand-computed expected mags/signs
    int vm[8];
    int vs[8];
    int em[8];
    int es[8];

    function automatic void check(input string name, input int act, input int req);
        n_total++;
        if (act == req)
            n_pass++;
        else
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
    endfunction

    task automatic push_exp(input int n);
        exp_t e;
        int   p;
        p = 0;
        for (int i = 0; i < n; i++) p = p ^ vs[i];
        for (int i = 0; i < n; i++) begin
            e.sign = es[i][0];
            e.mag  = 6'(em[i]);
            e.last = (i == n - 1);
            e.chk  = (i == n - 1) ? ~p[0] : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // returns at posedge+1 just after start was sampled
    task automatic do_start(input int cfg);
        int t;
        t = 0;
        while (bus.busy && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 300) check("start wait idle", 1, 0);
        bus.start  = 1'b1;
        bus.cfg_dc = 4'(cfg);
        @(posedge clk); #1;
        bus.start  = 1'b0;
    endtask

    // returns at posedge+1 just after the n-th accept
    task automatic send(input int n);
        logic ok;
        for (int i = 0; i < n; i++) begin
            bus.in_valid = 1'b1;
            bus.in_sign  = vs[i][0];
            bus.in_mag   = 6'(vm[i]);
            ok = 1'b0;
            for (int t = 0; t < 50 && !ok; t++) begin
                @(negedge clk);
                ok = bus.in_ready;
                @(posedge clk); #1;
            end
            if (!ok) check("in_ready timeout", 0, 1);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.busy) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain busy", int'(bus.busy), 0);
        check("drain queue", exp_q.size(), 0);
        @(posedge clk); #1;
    endtask

    // monitor: pops on every output handshake, checks hold during stalls
    logic       stalled = 1'b0;
    logic       h_sign, h_last;
    logic [5:0] h_mag;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled && bus.out_valid) begin
                check("hold mag",  int'(bus.out_mag),  int'(h_mag));
                check("hold sign", int'(bus.out_sign), int'(h_sign));
                check("hold last", int'(bus.out_last), int'(h_last));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_mag",  int'(bus.out_mag),  int'(e.mag));
                    check("out_sign", int'(bus.out_sign), int'(e.sign));
                    check("out_last", int'(bus.out_last), int'(e.last));
`ifdef CNU_PARITY_OUT_EN
                    check("chk_ok",   int'(bus.chk_ok),   int'(e.chk));
`endif
                end
            end
            stalled = bus.out_valid && !bus.out_ready;
            h_sign  = bus.out_sign;
            h_last  = bus.out_last;
            h_mag   = bus.out_mag;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.cfg_dc    = 4'd0;
        bus.in_valid  = 1'b0;
        bus.in_sign   = 1'b0;
        bus.in_mag    = 6'd0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy",      int'(bus.busy),      0);
        check("reset in_ready",  int'(bus.in_ready),  0);
        check("reset out_valid", int'(bus.out_valid), 0);
        check("reset out_last",  int'(bus.out_last),  0);
        check("reset out_sign",  int'(bus.out_sign),  0);
        check("reset out_mag",   int'(bus.out_mag),   0);
`ifdef CNU_PARITY_OUT_EN
        check("reset chk_ok",    int'(bus.chk_ok),    0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // dc=3: phi(4)=3, acc=9, phi(6)=2; parity 1
        vm = '{4, 4, 4, 0, 0, 0, 0, 0};
        vs = '{0, 0, 1, 0, 0, 0, 0, 0};
        em = '{2, 2, 2, 0, 0, 0, 0, 0};
        es = '{1, 1, 0, 0, 0, 0, 0, 0};
        push_exp(3); do_start(3); send(3); drain();

        // dc=6, all mag 0: phi 15 each, acc=90, diff 75 saturates to 63 -> phi 0
        vm = '{0, 0, 0, 0, 0, 0, 0, 0};
        vs = '{1, 0, 0, 1, 1, 0, 0, 0};
        em = '{0, 0, 0, 0, 0, 0, 0, 0};
        es = '{0, 1, 1, 0, 0, 1, 0, 0};
        push_exp(6); do_start(6); send(6); drain();

        // dc=4 with stall: phi 6,2,1,0, acc=9 -> phi(3)=4, phi(7)=1, phi(8)=1, phi(9)=1
        vm = '{2, 5, 8, 12, 0, 0, 0, 0};
        vs = '{1, 0, 0, 1, 0, 0, 0, 0};
        em = '{4, 1, 1, 1, 0, 0, 0, 0};
        es = '{1, 0, 0, 1, 0, 0, 0, 0};
        push_exp(4); do_start(4); send(4);
        @(posedge clk); #1;            // first output now valid
        @(posedge clk); #1;            // first transferred, second presented
        bus.out_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        bus.out_ready = 1'b1;
        drain();

        // reset after 2 of 5 loads, then a clean dc=2 run: phi 4,1, acc=5 -> phi(1)=8, phi(4)=3
        vm = '{1, 1, 1, 1, 1, 0, 0, 0};
        vs = '{1, 1, 1, 1, 1, 0, 0, 0};
        do_start(5); send(2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort busy",      int'(bus.busy),      0);
        check("abort in_ready",  int'(bus.in_ready),  0);
        check("abort out_valid", int'(bus.out_valid), 0);
        @(posedge clk); #1;
        vm = '{3, 7, 0, 0, 0, 0, 0, 0};
        vs = '{0, 1, 0, 0, 0, 0, 0, 0};
        em = '{8, 3, 0, 0, 0, 0, 0, 0};
        es = '{1, 0, 0, 0, 0, 0, 0, 0};
        push_exp(2); do_start(2); send(2); drain();

        // cfg_dc=1 clamps to 2; start pulses during LOAD and EMIT ignored
        // phi 15,0, acc=15 -> phi(0)=15, phi(15)=0
        vm = '{0, 12, 0, 0, 0, 0, 0, 0};
        vs = '{1, 1, 0, 0, 0, 0, 0, 0};
        em = '{15, 0, 0, 0, 0, 0, 0, 0};
        es = '{1, 1, 0, 0, 0, 0, 0, 0};
        push_exp(2); do_start(1);
        bus.start = 1'b1; bus.cfg_dc = 4'd5;
        @(posedge clk); #1;
        bus.start = 1'b0;
        send(2);
        bus.start = 1'b1; bus.cfg_dc = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("ignored start busy", int'(bus.busy), 0);
        @(posedge clk); #1;

        // cfg_dc=12 clamps to 8: phi 3 each, acc=24, diff 21 -> phi 0
        vm = '{4, 4, 4, 4, 4, 4, 4, 4};
        vs = '{0, 0, 0, 0, 0, 0, 0, 0};
        em = '{0, 0, 0, 0, 0, 0, 0, 0};
        es = '{0, 0, 0, 0, 0, 0, 0, 0};
        push_exp(8); do_start(12); send(8);
        @(negedge clk);
        check("in_ready after 8 loads", int'(bus.in_ready), 0);
        @(posedge clk); #1;
        drain();

`ifdef CNU_PARITY_OUT_EN
        // signs 1,1,0: parity 0 -> chk_ok 1 with last
        vm = '{4, 4, 4, 0, 0, 0, 0, 0};
        vs = '{1, 1, 0, 0, 0, 0, 0, 0};
        em = '{2, 2, 2, 0, 0, 0, 0, 0};
        es = '{1, 1, 0, 0, 0, 0, 0, 0};
        push_exp(3); do_start(3); send(3); drain();
        // signs 1,0,0: parity 1 -> chk_ok 0
        vs = '{1, 0, 0, 0, 0, 0, 0, 0};
        es = '{0, 1, 1, 0, 0, 0, 0, 0};
        push_exp(3); do_start(3); send(3); drain();
`endif

        check("final queue empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
